// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory-stage opcodes and stack defaults.
package pipeline_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned FLAG_W      = 3;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned ADDR_W_DEF  = 12;

  typedef enum logic [OP_W-1:0] {
    MOP_NOP   = 4'd0,
    MOP_LOAD  = 4'd1,
    MOP_STORE = 4'd2,
    MOP_PUSH  = 4'd3,
    MOP_POP   = 4'd4,
    MOP_CALL  = 4'd5,
    MOP_RET   = 4'd6,
    MOP_INT   = 4'd7,
    MOP_RTI   = 4'd8
  } mem_op_t;

  // Stack starts at the top word of the data memory.
  function automatic int unsigned sp_reset_default(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: one synchronous write port, one combinational read port.
module data_mem
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data memory, stack pointer and multi-cycle CALL/RET/INT/RTI sequencing.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned SP_RESET = sp_reset_default(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sp
);

  typedef enum logic [1:0] {S_IDLE, S_1, S_2} state_t;

  state_t            state_q, state_d;
  mem_op_t           op_q, op_d, op_in;
  logic [PC_W-1:0]   pc_hold_q, pc_hold_d;
  logic [FLAG_W-1:0] flags_hold_q, flags_hold_d;
  logic [DATA_W-1:0] pop_lo_q, pop_lo_d;
  logic [ADDR_W-1:0] sp_d, sp_inc, sp_dec;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_valid_d, pc_load_d, flags_load_d;
  logic [PC_W-1:0]   pc_out_d;
  logic [FLAG_W-1:0] flags_out_d;
  logic              stall_c;

  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] wdata, rdata_c;

  logic unused_addr_hi;
  assign unused_addr_hi = ^alu_result[DATA_W-1:ADDR_W];

  assign op_in  = mem_op_t'(mem_op);
  assign sp_inc = sp + ADDR_W'(1);
  assign sp_dec = sp - ADDR_W'(1);

  data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata_c (rdata_c)
  );

  // Stall is combinational so upstream freezes in the sampling cycle; forced low under reset.
  assign mem_stall = rst_n & stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= MOP_NOP;
      pc_hold_q    <= '0;
      flags_hold_q <= '0;
      pop_lo_q     <= '0;
      sp           <= ADDR_W'(SP_RESET);
      wb_data      <= '0;
      wb_valid     <= 1'b0;
      pc_out       <= '0;
      pc_load      <= 1'b0;
      flags_out    <= '0;
      flags_load   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      pc_hold_q    <= pc_hold_d;
      flags_hold_q <= flags_hold_d;
      pop_lo_q     <= pop_lo_d;
      sp           <= sp_d;
      wb_data      <= wb_data_d;
      wb_valid     <= wb_valid_d;
      pc_out       <= pc_out_d;
      pc_load      <= pc_load_d;
      flags_out    <= flags_out_d;
      flags_load   <= flags_load_d;
    end
  end

  // Next state, memory port control and next output values; one stack access per cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    pc_hold_d    = pc_hold_q;
    flags_hold_d = flags_hold_q;
    pop_lo_d     = pop_lo_q;
    sp_d         = sp;
    wb_data_d    = wb_data;
    wb_valid_d   = 1'b0;
    pc_out_d     = pc_out;
    pc_load_d    = 1'b0;
    flags_out_d  = flags_out;
    flags_load_d = 1'b0;
    stall_c      = 1'b0;
    we           = 1'b0;
    waddr        = sp;
    wdata        = store_data;
    raddr        = sp_inc;

    unique case (state_q)
      S_IDLE: begin
        op_d         = op_in;
        pc_hold_d    = pc_in;
        flags_hold_d = flags_in;
        case (op_in)
          MOP_LOAD: begin
            raddr      = alu_result[ADDR_W-1:0];
            wb_data_d  = rdata_c;
            wb_valid_d = 1'b1;
          end
          MOP_STORE: begin
            we    = 1'b1;
            waddr = alu_result[ADDR_W-1:0];
          end
          MOP_PUSH: begin
            we   = 1'b1;
            sp_d = sp_dec;
          end
          MOP_POP: begin
            sp_d       = sp_inc;
            wb_data_d  = rdata_c;
            wb_valid_d = 1'b1;
          end
          MOP_CALL, MOP_INT: begin
            we      = 1'b1;
            wdata   = pc_in[PC_W-1:DATA_W];
            sp_d    = sp_dec;
            state_d = S_1;
            stall_c = 1'b1;
          end
          MOP_RET: begin
            sp_d     = sp_inc;
            pop_lo_d = rdata_c;
            state_d  = S_1;
            stall_c  = 1'b1;
          end
          MOP_RTI: begin
            sp_d        = sp_inc;
            flags_out_d = rdata_c[FLAG_W-1:0];
            state_d     = S_1;
            stall_c     = 1'b1;
          end
          default: ;
        endcase
      end

      S_1: begin
        state_d = S_IDLE;
        case (op_q)
          MOP_CALL, MOP_INT: begin
            we    = 1'b1;
            wdata = pc_hold_q[DATA_W-1:0];
            sp_d  = sp_dec;
            if (op_q == MOP_INT) begin
              state_d = S_2;
              stall_c = 1'b1;
            end
          end
          MOP_RET: begin
            sp_d      = sp_inc;
            pc_out_d  = {rdata_c, pop_lo_q};
            pc_load_d = 1'b1;
          end
          MOP_RTI: begin
            sp_d     = sp_inc;
            pop_lo_d = rdata_c;
            state_d  = S_2;
            stall_c  = 1'b1;
          end
          default: ;
        endcase
      end

      S_2: begin
        state_d = S_IDLE;
        case (op_q)
          MOP_INT: begin
            we    = 1'b1;
            wdata = DATA_W'(flags_hold_q);
            sp_d  = sp_dec;
          end
          MOP_RTI: begin
            sp_d         = sp_inc;
            pc_out_d     = {rdata_c, pop_lo_q};
            pc_load_d    = 1'b1;
            flags_load_d = 1'b1;
          end
          default: ;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
